// File: rtl/easyaxi_mst_rd_arb.sv
`default_nettype none
// ============================================================================
// easyaxi_mst_rd_arb : round-robin AR arbiter + RID-based R router, REQ_NUM ports
// Option macro EASYAXI_RD_ARB_OST_LIMIT_EN masks requesters at OST_MAX bursts.
// Revision: 1.0
// ============================================================================
module easyaxi_mst_rd_arb #(
  parameter int REQ_NUM     = 4,
  parameter int OST_MAX     = 8,
  parameter int AXI_ID_W    = 4,
  parameter int AXI_ADDR_W  = 32,
  parameter int AXI_LEN_W   = 8,
  parameter int AXI_SIZE_W  = 3,
  parameter int AXI_BURST_W = 2,
  parameter int AXI_USER_W  = 4,
  parameter int AXI_DATA_W  = 32,
  parameter int AXI_RESP_W  = 2,
  localparam int REQ_W      = $clog2(REQ_NUM),
  localparam int OST_W      = $clog2(OST_MAX + 1)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [REQ_NUM-1:0]             req_arvalid,
  output logic [REQ_NUM-1:0]             req_arready,
  input  logic [REQ_NUM*AXI_ADDR_W-1:0]  req_araddr,
  input  logic [REQ_NUM*AXI_LEN_W-1:0]   req_arlen,
  input  logic [REQ_NUM*AXI_SIZE_W-1:0]  req_arsize,
  input  logic [REQ_NUM*AXI_BURST_W-1:0] req_arburst,
  input  logic [REQ_NUM*AXI_USER_W-1:0]  req_aruser,
  output logic [REQ_NUM-1:0]             req_rvalid,
  input  logic [REQ_NUM-1:0]             req_rready,
  output logic [AXI_DATA_W-1:0]          req_rdata,
  output logic [AXI_RESP_W-1:0]          req_rresp,
  output logic                           req_rlast,
  output logic [AXI_USER_W-1:0]          req_ruser,
  output logic                           axi_mst_arvalid,
  input  logic                           axi_mst_arready,
  output logic [AXI_ID_W-1:0]            axi_mst_arid,
  output logic [AXI_ADDR_W-1:0]          axi_mst_araddr,
  output logic [AXI_LEN_W-1:0]           axi_mst_arlen,
  output logic [AXI_SIZE_W-1:0]          axi_mst_arsize,
  output logic [AXI_BURST_W-1:0]         axi_mst_arburst,
  output logic [AXI_USER_W-1:0]          axi_mst_aruser,
  input  logic                           axi_mst_rvalid,
  output logic                           axi_mst_rready,
  input  logic [AXI_ID_W-1:0]            axi_mst_rid,
  input  logic [AXI_DATA_W-1:0]          axi_mst_rdata,
  input  logic [AXI_RESP_W-1:0]          axi_mst_rresp,
  input  logic                           axi_mst_rlast,
  input  logic [AXI_USER_W-1:0]          axi_mst_ruser,
  output logic [REQ_NUM*OST_W-1:0]       ost_cnt,
  output logic                           idle,
  output logic                           rid_err
);

  logic                   slot_vld_q,   slot_vld_d;
  logic [REQ_W-1:0]       slot_id_q,    slot_id_d;
  logic [AXI_ADDR_W-1:0]  slot_addr_q,  slot_addr_d;
  logic [AXI_LEN_W-1:0]   slot_len_q,   slot_len_d;
  logic [AXI_SIZE_W-1:0]  slot_size_q,  slot_size_d;
  logic [AXI_BURST_W-1:0] slot_burst_q, slot_burst_d;
  logic [AXI_USER_W-1:0]  slot_user_q,  slot_user_d;
  logic [REQ_W-1:0]       rr_ptr_q,     rr_ptr_d;
  logic [OST_W-1:0]       cnt_q [REQ_NUM];
  logic [OST_W-1:0]       cnt_d [REQ_NUM];
  logic                   rid_err_q,    rid_err_d;

  logic                   slot_free;
  logic                   ar_hs;
  logic                   r_hs;
  logic [REQ_NUM-1:0]     elig;
  logic [REQ_NUM-1:0]     inc;
  logic [REQ_NUM-1:0]     dec;
  logic                   gnt_vld;
  logic [REQ_W-1:0]       gnt_idx;
  logic [REQ_W:0]         rr_idx;
  logic [REQ_W-1:0]       rid_lo;
  logic                   id_hi_zero;
  logic                   rid_ok;

  assign slot_free = ~slot_vld_q | axi_mst_arready;
  assign ar_hs     = slot_vld_q & axi_mst_arready;
  assign r_hs      = axi_mst_rvalid & axi_mst_rready;

  // A command sitting in the slot counts against its owner until it handshakes.
  always_comb begin
    elig = '0;
    for (int k = 0; k < REQ_NUM; k++) begin
`ifdef EASYAXI_RD_ARB_OST_LIMIT_EN
      elig[k] = req_arvalid[k] &&
                (((OST_W+1)'(cnt_q[k]) +
                  (OST_W+1)'(slot_vld_q && (slot_id_q == REQ_W'(k))))
                 < (OST_W+1)'(OST_MAX));
`else
      elig[k] = req_arvalid[k];
`endif
    end
  end

  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = rr_ptr_q;
    rr_idx  = '0;
    for (int i = 0; i < REQ_NUM; i++) begin
      rr_idx = (REQ_W+1)'(rr_ptr_q) + (REQ_W+1)'(i);
      if (rr_idx >= (REQ_W+1)'(REQ_NUM)) rr_idx = rr_idx - (REQ_W+1)'(REQ_NUM);
      if (!gnt_vld && elig[rr_idx[REQ_W-1:0]]) begin
        gnt_vld = 1'b1;
        gnt_idx = rr_idx[REQ_W-1:0];
      end
    end
  end

  always_comb begin
    req_arready  = '0;
    slot_vld_d   = slot_vld_q & ~axi_mst_arready;
    slot_id_d    = slot_id_q;
    slot_addr_d  = slot_addr_q;
    slot_len_d   = slot_len_q;
    slot_size_d  = slot_size_q;
    slot_burst_d = slot_burst_q;
    slot_user_d  = slot_user_q;
    rr_ptr_d     = rr_ptr_q;
    if (slot_free && gnt_vld && !rst) begin
      slot_vld_d = 1'b1;
      slot_id_d  = gnt_idx;
      rr_ptr_d   = (gnt_idx == REQ_W'(REQ_NUM - 1)) ? '0 : gnt_idx + 1'b1;
      for (int k = 0; k < REQ_NUM; k++) begin
        if (gnt_idx == REQ_W'(k)) begin
          req_arready[k] = 1'b1;
          slot_addr_d    = req_araddr[k*AXI_ADDR_W +: AXI_ADDR_W];
          slot_len_d     = req_arlen[k*AXI_LEN_W +: AXI_LEN_W];
          slot_size_d    = req_arsize[k*AXI_SIZE_W +: AXI_SIZE_W];
          slot_burst_d   = req_arburst[k*AXI_BURST_W +: AXI_BURST_W];
          slot_user_d    = req_aruser[k*AXI_USER_W +: AXI_USER_W];
        end
      end
    end
  end

  assign rid_lo = axi_mst_rid[REQ_W-1:0];

  generate
    if (AXI_ID_W > REQ_W) begin : g_id_hi
      assign id_hi_zero = ~|axi_mst_rid[AXI_ID_W-1:REQ_W];
    end else begin : g_id_exact
      assign id_hi_zero = 1'b1;
    end
  endgenerate

  assign rid_ok = id_hi_zero && ((REQ_W+1)'(rid_lo) < (REQ_W+1)'(REQ_NUM));

  // Illegal RIDs are sunk here so a stray beat can never stall the fabric.
  always_comb begin
    req_rvalid     = '0;
    axi_mst_rready = ~rid_ok;
    for (int k = 0; k < REQ_NUM; k++) begin
      if (rid_ok && (rid_lo == REQ_W'(k))) begin
        req_rvalid[k]  = axi_mst_rvalid;
        axi_mst_rready = req_rready[k];
      end
    end
  end

  always_comb begin
    for (int k = 0; k < REQ_NUM; k++) begin
      inc[k]   = ar_hs && (slot_id_q == REQ_W'(k));
      dec[k]   = r_hs && axi_mst_rlast && rid_ok && (rid_lo == REQ_W'(k));
      cnt_d[k] = cnt_q[k];
      if (inc[k] && !dec[k] && (cnt_q[k] != OST_W'(OST_MAX))) cnt_d[k] = cnt_q[k] + 1'b1;
      else if (dec[k] && !inc[k] && (cnt_q[k] != '0))        cnt_d[k] = cnt_q[k] - 1'b1;
    end
    rid_err_d = rid_err_q | (r_hs & ~rid_ok);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      slot_vld_q   <= 1'b0;
      slot_id_q    <= '0;
      slot_addr_q  <= '0;
      slot_len_q   <= '0;
      slot_size_q  <= '0;
      slot_burst_q <= '0;
      slot_user_q  <= '0;
      rr_ptr_q     <= '0;
      rid_err_q    <= 1'b0;
      for (int k = 0; k < REQ_NUM; k++) cnt_q[k] <= '0;
    end else begin
      slot_vld_q   <= slot_vld_d;
      slot_id_q    <= slot_id_d;
      slot_addr_q  <= slot_addr_d;
      slot_len_q   <= slot_len_d;
      slot_size_q  <= slot_size_d;
      slot_burst_q <= slot_burst_d;
      slot_user_q  <= slot_user_d;
      rr_ptr_q     <= rr_ptr_d;
      rid_err_q    <= rid_err_d;
      for (int k = 0; k < REQ_NUM; k++) cnt_q[k] <= cnt_d[k];
    end
  end

  generate
    for (genvar k = 0; k < REQ_NUM; k++) begin : g_ost
      assign ost_cnt[k*OST_W +: OST_W] = cnt_q[k];
    end
  endgenerate

  always_comb begin
    idle = ~slot_vld_q;
    for (int k = 0; k < REQ_NUM; k++) idle = idle & (cnt_q[k] == '0);
  end

  assign axi_mst_arvalid = slot_vld_q;
  assign axi_mst_arid    = AXI_ID_W'(slot_id_q);
  assign axi_mst_araddr  = slot_addr_q;
  assign axi_mst_arlen   = slot_len_q;
  assign axi_mst_arsize  = slot_size_q;
  assign axi_mst_arburst = slot_burst_q;
  assign axi_mst_aruser  = slot_user_q;
  assign rid_err         = rid_err_q;

  assign req_rdata = axi_mst_rdata;
  assign req_rresp = axi_mst_rresp;
  assign req_rlast = axi_mst_rlast;
  assign req_ruser = axi_mst_ruser;

endmodule
`default_nettype wire

// File: tb/tb_easyaxi_mst_rd_arb.sv
`default_nettype none
// tb_easyaxi_mst_rd_arb: randomized requesters and AXI slave, spec-level model,
// AR scoreboard queue drained by an independent monitor.
module tb_easyaxi_mst_rd_arb;
  localparam int N = 3, OST_MAX = 2, IDW = 4, AW = 32, LW = 8, SW = 3, BW = 2;
  localparam int UW = 4, DW = 32, RW = 2;
  localparam int OW = $clog2(OST_MAX + 1);

  logic clk = 1'b0;
  logic rst;
  logic [N-1:0]    req_arvalid, req_arready, req_rvalid, req_rready;
  logic [N*AW-1:0] req_araddr;
  logic [N*LW-1:0] req_arlen;
  logic [N*SW-1:0] req_arsize;
  logic [N*BW-1:0] req_arburst;
  logic [N*UW-1:0] req_aruser;
  logic [DW-1:0]   req_rdata;
  logic [RW-1:0]   req_rresp;
  logic            req_rlast;
  logic [UW-1:0]   req_ruser;
  logic            axi_mst_arvalid, axi_mst_arready;
  logic [IDW-1:0]  axi_mst_arid;
  logic [AW-1:0]   axi_mst_araddr;
  logic [LW-1:0]   axi_mst_arlen;
  logic [SW-1:0]   axi_mst_arsize;
  logic [BW-1:0]   axi_mst_arburst;
  logic [UW-1:0]   axi_mst_aruser;
  logic            axi_mst_rvalid, axi_mst_rready;
  logic [IDW-1:0]  axi_mst_rid;
  logic [DW-1:0]   axi_mst_rdata;
  logic [RW-1:0]   axi_mst_rresp;
  logic            axi_mst_rlast;
  logic [UW-1:0]   axi_mst_ruser;
  logic [N*OW-1:0] ost_cnt;
  logic            idle, rid_err;

  easyaxi_mst_rd_arb #(
    .REQ_NUM(N), .OST_MAX(OST_MAX), .AXI_ID_W(IDW), .AXI_ADDR_W(AW), .AXI_LEN_W(LW),
    .AXI_SIZE_W(SW), .AXI_BURST_W(BW), .AXI_USER_W(UW), .AXI_DATA_W(DW), .AXI_RESP_W(RW)
  ) dut (
    .clk(clk), .rst(rst),
    .req_arvalid(req_arvalid), .req_arready(req_arready), .req_araddr(req_araddr),
    .req_arlen(req_arlen), .req_arsize(req_arsize), .req_arburst(req_arburst),
    .req_aruser(req_aruser), .req_rvalid(req_rvalid), .req_rready(req_rready),
    .req_rdata(req_rdata), .req_rresp(req_rresp), .req_rlast(req_rlast), .req_ruser(req_ruser),
    .axi_mst_arvalid(axi_mst_arvalid), .axi_mst_arready(axi_mst_arready),
    .axi_mst_arid(axi_mst_arid), .axi_mst_araddr(axi_mst_araddr), .axi_mst_arlen(axi_mst_arlen),
    .axi_mst_arsize(axi_mst_arsize), .axi_mst_arburst(axi_mst_arburst),
    .axi_mst_aruser(axi_mst_aruser), .axi_mst_rvalid(axi_mst_rvalid),
    .axi_mst_rready(axi_mst_rready), .axi_mst_rid(axi_mst_rid), .axi_mst_rdata(axi_mst_rdata),
    .axi_mst_rresp(axi_mst_rresp), .axi_mst_rlast(axi_mst_rlast), .axi_mst_ruser(axi_mst_ruser),
    .ost_cnt(ost_cnt), .idle(idle), .rid_err(rid_err)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic [IDW-1:0] id;
    logic [AW-1:0]  addr;
    logic [LW-1:0]  len;
    logic [SW-1:0]  size;
    logic [BW-1:0]  burst;
    logic [UW-1:0]  user;
  } ar_t;
  ar_t exp_ar[$];

  typedef struct { int id; int len; } burst_t;
  burst_t bursts[$];
  bit     r_pause;

  // Reference model: slot occupancy, round-robin pointer, saturating counters.
  bit m_occ;
  int m_id, m_rr;
  int m_cnt [N];
  bit m_err;

  initial begin : model
    ar_t e;
    int  g, rid, d;
    bit  free, legal, exp_rr, rhs, ar_hs, ok, exp_idle;
    int  hs_id;
    m_occ = 0; m_id = 0; m_rr = 0; m_err = 0;
    foreach (m_cnt[k]) m_cnt[k] = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        m_occ = 0; m_id = 0; m_rr = 0; m_err = 0;
        foreach (m_cnt[k]) m_cnt[k] = 0;
        exp_ar.delete();
        continue;
      end
      exp_idle = !m_occ;
      for (int k = 0; k < N; k++) begin
        check($sformatf("ost_cnt[%0d]", k), ost_cnt[k*OW +: OW], m_cnt[k]);
        if (m_cnt[k] != 0) exp_idle = 0;
      end
      check("idle", idle, exp_idle);
      check("rid_err", rid_err, m_err);

      rid    = int'(axi_mst_rid);
      legal  = (rid < N);
      exp_rr = legal ? req_rready[rid] : 1'b1;
      check("axi_rready", axi_mst_rready, exp_rr);
      check("req_rvalid", req_rvalid, (legal && axi_mst_rvalid) ? (64'd1 << rid) : 64'd0);
      if (axi_mst_rvalid) begin
        check("rdata", req_rdata, axi_mst_rdata);
        check("rlast", req_rlast, axi_mst_rlast);
      end
      rhs = axi_mst_rvalid && exp_rr;

      free = !m_occ || axi_mst_arready;
      g = -1;
      if (free) begin
        for (int i = 0; i < N; i++) begin
          int k;
          k = (m_rr + i) % N;
`ifdef EASYAXI_RD_ARB_OST_LIMIT_EN
          ok = req_arvalid[k] && (m_cnt[k] + ((m_occ && m_id == k) ? 1 : 0) < OST_MAX);
`else
          ok = req_arvalid[k];
`endif
          if (g < 0 && ok) g = k;
        end
      end
      check("req_arready", req_arready, (g < 0) ? 64'd0 : (64'd1 << g));
      if (g >= 0) begin
        e.id    = IDW'(g);
        e.addr  = req_araddr[g*AW +: AW];
        e.len   = req_arlen[g*LW +: LW];
        e.size  = req_arsize[g*SW +: SW];
        e.burst = req_arburst[g*BW +: BW];
        e.user  = req_aruser[g*UW +: UW];
      end
      ar_hs = m_occ && axi_mst_arready;
      hs_id = m_id;

      @(posedge clk);
      if (ar_hs) m_occ = 0;
      if (g >= 0) begin
        m_occ = 1; m_id = g; m_rr = (g + 1) % N;
        exp_ar.push_back(e);
      end
      for (int k = 0; k < N; k++) begin
        d = ((ar_hs && hs_id == k) ? 1 : 0) - ((rhs && legal && axi_mst_rlast && rid == k) ? 1 : 0);
        m_cnt[k] = m_cnt[k] + d;
        if (m_cnt[k] > OST_MAX) m_cnt[k] = OST_MAX;
        if (m_cnt[k] < 0)       m_cnt[k] = 0;
      end
      if (rhs && !legal) m_err = 1;
    end
  end

  // AR monitor: the front entry must be presented from the cycle after the grant
  // and held unchanged until the handshake.
  initial begin : ar_monitor
    forever begin
      @(negedge clk);
      if (rst) continue;
      if (axi_mst_arvalid) begin
        if (exp_ar.size() == 0) begin
          total++; bad++;
          $display("FAIL ar_unexpected: got arid 0x%0h expected no AR at %0t", axi_mst_arid, $time);
        end else begin
          check("arid",    axi_mst_arid,    exp_ar[0].id);
          check("araddr",  axi_mst_araddr,  exp_ar[0].addr);
          check("arlen",   axi_mst_arlen,   exp_ar[0].len);
          check("arsize",  axi_mst_arsize,  exp_ar[0].size);
          check("arburst", axi_mst_arburst, exp_ar[0].burst);
          check("aruser",  axi_mst_aruser,  exp_ar[0].user);
          if (axi_mst_arready) void'(exp_ar.pop_front());
        end
      end else if (exp_ar.size() != 0) begin
        check("arvalid", axi_mst_arvalid, 1);
      end
    end
  end

  // AXI slave: in-order R bursts for accepted ARs, plus occasional illegal-RID beats.
  initial begin : slave
    bit rhs, cur_illegal;
    int beat;
    axi_mst_rvalid = 0; axi_mst_rid = '0; axi_mst_rdata = '0;
    axi_mst_rresp = '0; axi_mst_rlast = 0; axi_mst_ruser = '0;
    cur_illegal = 0; beat = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        bursts.delete(); beat = 0;
        continue;
      end
      rhs = axi_mst_rvalid && axi_mst_rready;
      if (axi_mst_arvalid && axi_mst_arready)
        bursts.push_back('{int'(axi_mst_arid), int'(axi_mst_arlen)});
      @(posedge clk); #1;
      if (rhs) begin
        if (!cur_illegal) begin
          if (axi_mst_rlast) begin void'(bursts.pop_front()); beat = 0; end
          else beat++;
        end
        axi_mst_rvalid = 0;
      end
      if (!axi_mst_rvalid) begin
        if ($urandom_range(0, 31) == 0) begin
          cur_illegal    = 1;
          axi_mst_rvalid = 1;
          axi_mst_rid    = ($urandom_range(0, 1) == 0) ? IDW'(3) : IDW'($urandom_range(4, 15));
          axi_mst_rlast  = 1'($urandom_range(0, 1));
        end else if (!r_pause && bursts.size() > 0 && $urandom_range(0, 3) != 0) begin
          cur_illegal    = 0;
          axi_mst_rvalid = 1;
          axi_mst_rid    = IDW'(bursts[0].id);
          axi_mst_rlast  = (beat == bursts[0].len);
        end
        axi_mst_rdata = $urandom();
        axi_mst_rresp = RW'($urandom());
        axi_mst_ruser = UW'($urandom());
      end
    end
  end

  logic [N-1:0] drv_done;

  initial begin : driver
    rst = 1; req_arvalid = '1; req_rready = '0; axi_mst_arready = 1; r_pause = 1;
    req_araddr = '0; req_arlen = '0; req_arsize = '0; req_arburst = '0; req_aruser = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_arvalid",  axi_mst_arvalid, 0);
    check("rst_arready",  req_arready, 0);
    check("rst_idle",     idle, 1);
    check("rst_rid_err",  rid_err, 0);
    check("rst_ost_cnt",  ost_cnt, 0);
    check("rst_araddr",   axi_mst_araddr, 0);
    @(posedge clk); #1;
    rst = 0; req_arvalid = '0;

    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      drv_done = req_arvalid & req_arready;
      @(posedge clk); #1;
      r_pause = (c < 60);
      for (int k = 0; k < N; k++) begin
        if (!req_arvalid[k] || drv_done[k]) begin
          req_arvalid[k] = (c < 2400) &&
                           ((c < 60) ? ($urandom_range(0, 2) != 0) : ($urandom_range(0, 15) == 0));
          if (req_arvalid[k]) begin
            req_araddr[k*AW +: AW]  = $urandom();
            req_arlen[k*LW +: LW]   = LW'($urandom_range(0, 3));
            req_arsize[k*SW +: SW]  = SW'($urandom());
            req_arburst[k*BW +: BW] = BW'($urandom());
            req_aruser[k*UW +: UW]  = UW'($urandom());
          end
        end
        req_rready[k] = ($urandom_range(0, 3) != 0);
      end
      if ((c % 200) >= 100 && (c % 200) < 105) axi_mst_arready = 0;
      else axi_mst_arready = ($urandom_range(0, 3) != 0);
    end

    req_arvalid = '0;
    for (int w = 0; w < 3000 && !(idle && bursts.size() == 0 && !axi_mst_rvalid); w++)
      @(posedge clk);
    @(negedge clk);
    check("drain_idle", idle, 1);
    check("drain_bursts_left", bursts.size(), 0);
    check("rid_err_sticky", rid_err, m_err);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
